fifo_read_ctrl: RTL

- Read side of the 8-entry register FIFO; the counterpart of the write-enable decode path.
- Owns the read pointer and the occupancy count.
- Selects the head entry from the flattened register-file outputs and returns it on a registered data port.
- Reports a per-request read acknowledge or read error and the empty flag.

---
 rtl/fifo_read_ctrl.sv | 48 ++++
 1 files changed

// File: rtl/fifo_read_ctrl.sv
// fifo_read_ctrl: read pointer, occupancy count and registered head-entry read port of the 8-entry register FIFO
module fifo_read_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         rd_en,
  input  logic                         wr_ok,
  input  logic [8*DATA_WIDTH-1:0]      reg_data,
  output logic [DEPTH_LOG2-1:0]        rd_addr,
  output logic [DATA_WIDTH-1:0]        dout,
  output logic                         rd_ack,
  output logic                         rd_err,
  output logic                         empty,
  output logic [DEPTH_LOG2:0]          data_count
);
  localparam logic [DEPTH_LOG2:0] full_cnt = (DEPTH_LOG2+1)'(8);
  logic                  acc;
  logic [DATA_WIDTH-1:0] head;
  logic [DEPTH_LOG2:0]   count_nxt;
  always_comb begin
    acc       = rd_en && (data_count != '0);
    head      = reg_data[32'(rd_addr)*DATA_WIDTH +: DATA_WIDTH];
    count_nxt = (acc && wr_ok) ? data_count :
                acc            ? data_count - 1'b1 :
                wr_ok          ? ((data_count == full_cnt) ? full_cnt : data_count + 1'b1) :
                                 data_count;
  end
  assign empty = (data_count == '0);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_addr    <= '0;
      dout       <= '0;
      rd_ack     <= 1'b0;
      rd_err     <= 1'b0;
      data_count <= '0;
    end else begin
      rd_ack     <= acc;
      rd_err     <= rd_en && !acc;
      data_count <= count_nxt;
      if (acc) begin
        dout    <= head;
        rd_addr <= rd_addr + 1'b1;
      end
    end
  end
endmodule
